// File: rtl/cl_sde_srm_pack_pkg.sv
// Shared constants and types for the SDE stream packer: register map, CTRL bits,
// default read value and the STATUS layout.
package cl_sde_pack_pkg;
  localparam logic [11:0] REG_CTRL      = 12'h000;
  localparam logic [11:0] REG_PKT_LEN   = 12'h004;
  localparam logic [11:0] REG_OUT_BEATS = 12'h008;
  localparam logic [11:0] REG_OUT_PKTS  = 12'h00C;
  localparam logic [11:0] REG_STATUS    = 12'h010;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_FLUSH  = 1;

  localparam logic [31:0] RD_DEFAULT = 32'hDEADBEEF;

  typedef struct packed {
    logic stalled;
    logic ots_valid;
    logic acc_nonempty;
  } status_t;
endpackage

// File: rtl/cl_sde_srm_pack_if.sv
// Input element stream plus packed AXIS output stream of the packer.
// master = packer side, slave = upstream source / downstream sink side.
interface cl_sde_srm_pack_if #(
  parameter int IN_W   = 16,
  parameter int BUS_W  = 512,
  parameter int USER_W = 64
);
  logic              ins_valid;
  logic              ins_ready;
  logic [IN_W-1:0]   ins_data;
  logic              ots_valid;
  logic              ots_ready;
  logic              ots_last;
  logic [BUS_W-1:0]  ots_data;
  logic [BUS_W/8-1:0] ots_keep;
  logic [USER_W-1:0] ots_user;

  modport master (input ins_valid, ins_data, ots_ready,
                  output ins_ready, ots_valid, ots_data, ots_keep, ots_user, ots_last);
  modport slave  (output ins_valid, ins_data, ots_ready,
                  input ins_ready, ots_valid, ots_data, ots_keep, ots_user, ots_last);
endinterface

// File: rtl/cl_sde_srm_pack_regs.sv
// cfg window of the packer: decode, 1-cycle ack, CTRL/PKT_LEN, status readback.
// Beat/packet counters exist only when CL_SDE_PACK_STATS_EN is defined.
module cl_sde_pack_regs import cl_sde_pack_pkg::*; (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] cfg_addr,
   input  logic        cfg_wr,
   input  logic        cfg_rd,
   input  logic [31:0] cfg_wdata,
   output logic        cfg_ack,
   output logic [31:0] cfg_rdata,
   input  status_t     i_status,
   input  logic        i_beat,
   input  logic        i_pkt,
   output logic        o_enable,
   output logic        o_flush,
   output logic [31:0] o_pkt_len
);
   logic        r_enable;
   logic [31:0] r_pkt_len;
   logic [31:0] w_beats, w_pkts, w_rd;

   // FLUSH is never stored: it acts on the same edge as the write
   assign o_flush   = cfg_wr && (cfg_addr == REG_CTRL) && cfg_wdata[CTRL_FLUSH];
   assign o_enable  = r_enable;
   assign o_pkt_len = r_pkt_len;

`ifdef CL_SDE_PACK_STATS_EN
   logic [31:0] r_beats, r_pkts;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beats <= '0;
         r_pkts  <= '0;
      end else begin
         if (i_beat) r_beats <= r_beats + 32'd1;
         if (i_pkt)  r_pkts  <= r_pkts + 32'd1;
      end
   end
   assign w_beats = r_beats;
   assign w_pkts  = r_pkts;
`else
   logic w_unused_stats;
   assign w_unused_stats = i_beat ^ i_pkt;
   assign w_beats = '0;
   assign w_pkts  = '0;
`endif

   always_comb begin
      w_rd = RD_DEFAULT;
      case (cfg_addr)
         REG_CTRL:      w_rd = {31'd0, r_enable};
         REG_PKT_LEN:   w_rd = r_pkt_len;
         REG_OUT_BEATS: w_rd = w_beats;
         REG_OUT_PKTS:  w_rd = w_pkts;
         REG_STATUS:    w_rd = {29'd0, i_status};
         default:       w_rd = RD_DEFAULT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_enable  <= 1'b0;
         r_pkt_len <= '0;
         cfg_ack   <= 1'b0;
         cfg_rdata <= '0;
      end else begin
         cfg_ack   <= cfg_wr || cfg_rd;
         cfg_rdata <= cfg_rd ? w_rd : 32'd0;
         if (cfg_wr) begin
            if (cfg_addr == REG_CTRL)    r_enable  <= cfg_wdata[CTRL_ENABLE];
            if (cfg_addr == REG_PKT_LEN) r_pkt_len <= cfg_wdata;
         end
      end
   end
endmodule

// File: rtl/cl_sde_srm_pack.sv
// SDE stream packer: gathers IN_ELEMS-wide element beats into BUS_W-bit AXIS beats
// with PKT_LEN-based tlast and software flush. Optional stats: CL_SDE_PACK_STATS_EN.
module cl_sde_srm_pack import cl_sde_pack_pkg::*; #(
   parameter int ELEM_W   = 16,
   parameter int IN_ELEMS = 1,
   parameter int BUS_W    = 512,
   parameter int USER_W   = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] cfg_addr,
   input  logic        cfg_wr,
   input  logic        cfg_rd,
   input  logic [31:0] cfg_wdata,
   output logic        cfg_ack,
   output logic [31:0] cfg_rdata,
   cl_sde_srm_pack_if.master bus
);
   localparam int LANES = BUS_W / ELEM_W;
   localparam int IN_W  = IN_ELEMS * ELEM_W;
   localparam int NSLOT = LANES / IN_ELEMS;
   localparam int SW    = $clog2(NSLOT + 1);
   localparam int EB    = ELEM_W / 8;

   // Accumulator is addressed in input-beat slots; its flat layout equals lane order
   logic [NSLOT-1:0][IN_W-1:0] r_acc, w_acc, w_src_acc;
   logic [SW-1:0]    r_cnt, w_cnt, w_src_cnt;
   logic [31:0]      r_pkt_cnt, w_pkt_cnt, w_pkt_len;
   logic             r_acc_done, r_acc_last, w_src_last;
   logic             w_enable, w_flush, w_accept, w_slot_free;
   logic             w_len_hit, w_complete, w_last, w_load;
   logic [15:0]      w_lanes, r_ots_cnt;
   logic [BUS_W/8-1:0] w_keep, r_ots_keep;
   logic [BUS_W-1:0] r_ots_data;
   logic             r_ots_valid, r_ots_last;
   status_t          w_status;

   assign bus.ins_ready = w_enable && !r_acc_done;
   assign w_accept      = bus.ins_valid && bus.ins_ready;
   assign w_slot_free   = !r_ots_valid || bus.ots_ready;

   always_comb begin
      w_acc     = r_acc;
      w_cnt     = r_cnt;
      w_pkt_cnt = r_pkt_cnt;
      w_len_hit = 1'b0;
      if (w_accept) begin
         for (int i = 0; i < NSLOT; i++)
            if (SW'(i) == r_cnt) w_acc[i] = bus.ins_data;
         w_cnt     = r_cnt + 1'b1;
         w_pkt_cnt = r_pkt_cnt + 32'd1;
         w_len_hit = (w_pkt_len != 32'd0) && (w_pkt_cnt == w_pkt_len);
      end
      // a flush sees the beat accepted in the same cycle
      w_complete = !r_acc_done && (w_len_hit || (w_accept && (w_cnt == SW'(NSLOT))) ||
                                   (w_flush && (w_cnt != '0)));
      w_last     = w_len_hit || w_flush;
      w_load     = w_slot_free && (r_acc_done || w_complete);
      w_src_acc  = r_acc_done ? r_acc      : w_acc;
      w_src_cnt  = r_acc_done ? r_cnt      : w_cnt;
      w_src_last = r_acc_done ? r_acc_last : w_last;
      w_lanes    = 16'(w_src_cnt) * 16'(IN_ELEMS);
      w_keep     = '0;
      for (int i = 0; i < LANES; i++)
         w_keep[i*EB +: EB] = {EB{16'(i) < w_lanes}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_pkt_cnt   <= '0;
         r_acc_done  <= 1'b0;
         r_acc_last  <= 1'b0;
         r_ots_valid <= 1'b0;
         r_ots_data  <= '0;
         r_ots_keep  <= '0;
         r_ots_cnt   <= '0;
         r_ots_last  <= 1'b0;
      end else begin
         // load wins over drain so back-to-back beats keep ots_valid high
         if (w_load) begin
            r_ots_valid <= 1'b1;
            r_ots_data  <= w_src_acc;
            r_ots_keep  <= w_keep;
            r_ots_cnt   <= w_lanes;
            r_ots_last  <= w_src_last;
         end else if (bus.ots_ready) begin
            r_ots_valid <= 1'b0;
         end
         if (w_load) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_acc_done <= 1'b0;
            r_acc_last <= 1'b0;
         end else if (w_complete) begin
            r_acc      <= w_acc;
            r_cnt      <= w_cnt;
            r_acc_done <= 1'b1;
            r_acc_last <= w_last;
         end else begin
            r_acc <= w_acc;
            r_cnt <= w_cnt;
         end
         r_pkt_cnt <= (w_complete && w_last) ? 32'd0 : w_pkt_cnt;
      end
   end

   assign bus.ots_valid = r_ots_valid;
   assign bus.ots_data  = r_ots_data;
   assign bus.ots_keep  = r_ots_keep;
   assign bus.ots_user  = USER_W'(r_ots_cnt);
   assign bus.ots_last  = r_ots_last;

   assign w_status.acc_nonempty = (r_cnt != '0);
   assign w_status.ots_valid    = r_ots_valid;
   assign w_status.stalled      = r_acc_done;

   cl_sde_pack_regs u_regs (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_addr  (cfg_addr),
      .cfg_wr    (cfg_wr),
      .cfg_rd    (cfg_rd),
      .cfg_wdata (cfg_wdata),
      .cfg_ack   (cfg_ack),
      .cfg_rdata (cfg_rdata),
      .i_status  (w_status),
      .i_beat    (r_ots_valid && bus.ots_ready),
      .i_pkt     (r_ots_valid && bus.ots_ready && r_ots_last),
      .o_enable  (w_enable),
      .o_flush   (w_flush),
      .o_pkt_len (w_pkt_len)
   );
endmodule

// File: tb/tb_cl_sde_srm_pack.sv
// Directed bench for cl_sde_srm_pack: default instance (IN_ELEMS=1) plus an
// IN_ELEMS=4 instance sharing the cfg bus; expected beats are queued and compared on transfer.
module tb_cl_sde_srm_pack;
   import cl_sde_pack_pkg::*;

`ifdef CL_SDE_PACK_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      logic [511:0] data;
      logic [63:0]  keep;
      logic [63:0]  user;
      logic         last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] cfg_addr = '0;
   logic        cfg_wr = 1'b0, cfg_rd = 1'b0;
   logic [31:0] cfg_wdata = '0;
   logic        cfg_ack, ack4;
   logic [31:0] cfg_rdata, rdata4;

   int checks = 0;
   int failures = 0;
   beat_t exp_q[$];
   beat_t exp4_q[$];

   cl_sde_srm_pack_if #(.IN_W(16), .BUS_W(512), .USER_W(64)) ifc ();
   cl_sde_srm_pack_if #(.IN_W(64), .BUS_W(512), .USER_W(64)) if4 ();

   cl_sde_srm_pack u_dut (
      .clk(clk), .rst_n(rst_n), .cfg_addr(cfg_addr), .cfg_wr(cfg_wr), .cfg_rd(cfg_rd),
      .cfg_wdata(cfg_wdata), .cfg_ack(cfg_ack), .cfg_rdata(cfg_rdata), .bus(ifc));

   cl_sde_srm_pack #(.IN_ELEMS(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .cfg_addr(cfg_addr), .cfg_wr(cfg_wr), .cfg_rd(cfg_rd),
      .cfg_wdata(cfg_wdata), .cfg_ack(ack4), .cfg_rdata(rdata4), .bus(if4));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic beat_t make_beat(input int first, input int n, input logic l);
      beat_t b;
      b.data = '0;
      b.keep = '0;
      for (int i = 0; i < n; i++) begin
         b.data[i*16 +: 16] = 16'(first + i);
         b.keep[i*2 +: 2]   = 2'b11;
      end
      b.user = 64'(n);
      b.last = l;
      return b;
   endfunction

   // Compare each beat while it is presented with ready high; it transfers on the next edge
   always @(negedge clk) begin
      if (rst_n && ifc.ots_valid && ifc.ots_ready) begin
         if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
         else begin
            beat_t e;
            e = exp_q.pop_front();
            check("beat_data", ifc.ots_data, e.data);
            check("beat_keep", 512'(ifc.ots_keep), 512'(e.keep));
            check("beat_user", 512'(ifc.ots_user), 512'(e.user));
            check("beat_last", 512'(ifc.ots_last), 512'(e.last));
         end
      end
      if (rst_n && if4.ots_valid && if4.ots_ready) begin
         if (exp4_q.size() == 0) check("unexpected_beat4", 1, 0);
         else begin
            beat_t e;
            e = exp4_q.pop_front();
            check("beat4_data", if4.ots_data, e.data);
            check("beat4_keep", 512'(if4.ots_keep), 512'(e.keep));
            check("beat4_user", 512'(if4.ots_user), 512'(e.user));
            check("beat4_last", 512'(if4.ots_last), 512'(e.last));
         end
      end
   end

   task automatic cfg_write(input logic [11:0] a, input logic [31:0] d);
      cfg_addr = a; cfg_wdata = d; cfg_wr = 1'b1;
      @(posedge clk); #1;
      cfg_wr = 1'b0;
      check("wr_ack", 512'(cfg_ack), 512'(1));
   endtask

   task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
      cfg_addr = a; cfg_rd = 1'b1;
      @(posedge clk); #1;
      cfg_rd = 1'b0;
      check("rd_ack", 512'(cfg_ack), 512'(1));
      check(tag, 512'(cfg_rdata), 512'(exp));
   endtask

   task automatic push(input int v);
      int t = 0;
      ifc.ins_valid = 1'b1;
      ifc.ins_data  = 16'(v);
      forever begin
         @(negedge clk);
         if (ifc.ins_ready) break;
         t++;
         if (t > 2000) begin check("push_timeout", 1, 0); break; end
      end
      @(posedge clk); #1;
      ifc.ins_valid = 1'b0;
   endtask

   task automatic push4(input int v);
      int t = 0;
      if4.ins_valid = 1'b1;
      for (int j = 0; j < 4; j++) if4.ins_data[j*16 +: 16] = 16'(v + j);
      forever begin
         @(negedge clk);
         if (if4.ins_ready) break;
         t++;
         if (t > 2000) begin check("push4_timeout", 1, 0); break; end
      end
      @(posedge clk); #1;
      if4.ins_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int t = 0;
      while ((exp_q.size() != 0 || exp4_q.size() != 0) && t < 2000) begin
         @(posedge clk); t++;
      end
      #1;
      check(tag, 512'(exp_q.size() + exp4_q.size()), 512'(0));
   endtask

   initial begin
      logic [511:0] held;
      ifc.ins_valid = 1'b0; ifc.ins_data = '0; ifc.ots_ready = 1'b0;
      if4.ins_valid = 1'b0; if4.ins_data = '0; if4.ots_ready = 1'b1;

      // reset values
      #12;
      check("rst_ins_ready", 512'(ifc.ins_ready), 512'(0));
      check("rst_ots_valid", 512'(ifc.ots_valid), 512'(0));
      check("rst_ots_data",  ifc.ots_data, 512'(0));
      check("rst_ots_keep",  512'(ifc.ots_keep), 512'(0));
      check("rst_ots_user",  512'(ifc.ots_user), 512'(0));
      check("rst_ots_last",  512'(ifc.ots_last), 512'(0));
      check("rst_cfg_ack",   512'(cfg_ack), 512'(0));
      check("rst_cfg_rdata", 512'(cfg_rdata), 512'(0));
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      rd_chk("unmapped_rd", 12'h020, 32'hDEADBEEF);
      cfg_write(12'h040, 32'h1234);
      rd_chk("pkt_len_rst", REG_PKT_LEN, 32'd0);
      rd_chk("ctrl_rst", REG_CTRL, 32'd0);
      check("ready_disabled", 512'(ifc.ins_ready), 512'(0));
      ifc.ots_ready = 1'b1;

      // 1: one full packet of 32 lanes
      cfg_write(REG_PKT_LEN, 32'd32);
      cfg_write(REG_CTRL, 32'h1);
      rd_chk("ctrl_en", REG_CTRL, 32'h1);
      exp_q.push_back(make_beat(0, 32, 1'b1));
      for (int i = 0; i < 32; i++) push(i);
      wait_drain("t1_drain");
      rd_chk("t1_out_pkts", REG_OUT_PKTS, STATS ? 32'd1 : 32'd0);
      rd_chk("t1_out_beats", REG_OUT_BEATS, STATS ? 32'd1 : 32'd0);

      // 2: packet longer than a beat
      cfg_write(REG_PKT_LEN, 32'd40);
      exp_q.push_back(make_beat(100, 32, 1'b0));
      exp_q.push_back(make_beat(132, 8, 1'b1));
      for (int i = 0; i < 40; i++) push(100 + i);
      wait_drain("t2_drain");

      // 3: unbounded packet closed by flush; flush of empty accumulator is a no-op
      cfg_write(REG_PKT_LEN, 32'd0);
      for (int i = 0; i < 5; i++) push(200 + i);
      rd_chk("t3_status_nonempty", REG_STATUS, 32'h1);
      exp_q.push_back(make_beat(200, 5, 1'b1));
      cfg_write(REG_CTRL, 32'h3);
      wait_drain("t3_drain");
      rd_chk("t3_status_empty", REG_STATUS, 32'h0);
      rd_chk("t3_ctrl_flush_rd0", REG_CTRL, 32'h1);
      cfg_write(REG_CTRL, 32'h3);
      repeat (5) @(posedge clk);
      #1 check("t3_empty_flush", 512'(ifc.ots_valid), 512'(0));

      // 4: output stalled for 100 cycles while 64 elements are offered
      ifc.ots_ready = 1'b0;
      exp_q.push_back(make_beat(300, 32, 1'b0));
      exp_q.push_back(make_beat(332, 32, 1'b0));
      fork
         for (int i = 0; i < 64; i++) push(300 + i);
         begin
            repeat (80) @(posedge clk);
            #1;
            check("t4_ins_ready_stalled", 512'(ifc.ins_ready), 512'(0));
            check("t4_ots_valid_stalled", 512'(ifc.ots_valid), 512'(1));
            held = ifc.ots_data;
            rd_chk("t4_status_stalled", REG_STATUS, 32'h7);
            repeat (18) @(posedge clk);
            #1;
            check("t4_data_hold", ifc.ots_data, held);
            check("t4_data_value", ifc.ots_data, make_beat(300, 32, 1'b0).data);
            ifc.ots_ready = 1'b1;
         end
      join
      wait_drain("t4_drain");
      repeat (5) @(posedge clk);
      #1 check("t4_no_extra", 512'(ifc.ots_valid), 512'(0));

      // 5: IN_ELEMS=4 instance, PKT_LEN=10 input beats
      cfg_write(REG_PKT_LEN, 32'd10);
      exp4_q.push_back(make_beat(400, 32, 1'b0));
      exp4_q.push_back(make_beat(432, 8, 1'b1));
      for (int i = 0; i < 10; i++) push4(400 + 4 * i);
      wait_drain("t5_drain");

      // 6: async reset mid-packet
      cfg_write(REG_PKT_LEN, 32'd32);
      for (int i = 0; i < 7; i++) push(600 + i);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_ots_valid", 512'(ifc.ots_valid), 512'(0));
      check("t6_rst_ins_ready", 512'(ifc.ins_ready), 512'(0));
      check("t6_rst_ots_data", ifc.ots_data, 512'(0));
      @(posedge clk); #1 rst_n = 1'b1;
      rd_chk("t6_status", REG_STATUS, 32'h0);
      rd_chk("t6_out_beats", REG_OUT_BEATS, 32'd0);
      rd_chk("t6_out_pkts", REG_OUT_PKTS, 32'd0);
      cfg_write(REG_PKT_LEN, 32'd32);
      cfg_write(REG_CTRL, 32'h1);
      exp_q.push_back(make_beat(500, 32, 1'b1));
      for (int i = 0; i < 32; i++) push(500 + i);
      wait_drain("t6_drain");
      rd_chk("t6_out_pkts_after", REG_OUT_PKTS, STATS ? 32'd1 : 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
